ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte with odd parity
// on device-generated clocks, checks the device ACK and recovers on timeout or missing ACK.
module ps2_host_tx #(
  parameter int INHIBIT_TICKS = 100,
  parameter int TIMEOUT_TICKS = 15000
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       clk_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int TMAX = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_DATA    = 3'd3,
    ST_PARITY  = 3'd4,
    ST_STOP    = 3'd5,
    ST_ACK     = 3'd6,
    ST_RECOVER = 3'd7
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t          state_r, state_n;
  logic [TW-1:0]   timer_r, timer_n;
  logic [3:0]      bit_cnt_r, bit_cnt_n;
  logic [7:0]      shift_r, shift_n;
  logic            parity_r, parity_n;
  logic [2:0]      clk_sync_r;
  logic [1:0]      data_sync_r;
  logic            clk_now_s, data_now_s, fall_s;
  logic            clk_low_n, data_low_n, done_n, err_n;

  assign clk_now_s  = clk_sync_r[1];
  assign data_now_s = data_sync_r[1];
  assign fall_s     = clk_sync_r[2] & ~clk_sync_r[1];

  // Two-flop synchronizers on the raw lines, plus one history flop for clock edge detection
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], ps2_clk_in};
      data_sync_r <= {data_sync_r[0], ps2_data_in};
    end
  end

  // State, timer, bit counter and frame registers
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TW{1'b0}};
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
    end else begin
      state_r   <= state_n;
      timer_r   <= timer_n;
      bit_cnt_r <= bit_cnt_n;
      shift_r   <= shift_n;
      parity_r  <= parity_n;
    end
  end

  // Next-state and next-output logic; the line drives are registered below so they follow the state
  always_comb begin
    state_n    = state_r;
    timer_n    = timer_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    parity_n   = parity_r;
    clk_low_n  = 1'b0;
    data_low_n = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid) begin
          shift_n   = tx_data;
          parity_n  = odd_parity(tx_data);
          timer_n   = {TW{1'b0}};
          bit_cnt_n = 4'd0;
          clk_low_n = 1'b1;
          state_n   = ST_INHIBIT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        clk_low_n = 1'b1;
        if (clk_en) begin
          if (timer_r == INH_LAST) begin
            timer_n    = {TW{1'b0}};
            clk_low_n  = 1'b0;
            data_low_n = 1'b1;
            state_n    = ST_REQ;
          end else begin
            timer_n = timer_r + TW'(1);
          end
        end else begin
          timer_n = timer_r;
        end
      end
      ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK: begin
        data_low_n = ps2_data_low;
        if (clk_en && (timer_r == TMO_LAST)) begin
          // Device stopped clocking or never ACKed: free the bus and report
          timer_n    = {TW{1'b0}};
          data_low_n = 1'b0;
          err_n      = 1'b1;
          state_n    = ST_RECOVER;
        end else begin
          timer_n = clk_en ? (timer_r + TW'(1)) : timer_r;
          case (state_r)
            ST_REQ: begin
              if (fall_s) begin
                data_low_n = ~shift_r[0];
                bit_cnt_n  = 4'd1;
                state_n    = ST_DATA;
              end else begin
                data_low_n = 1'b1;
              end
            end
            ST_DATA: begin
              if (fall_s) begin
                if (bit_cnt_r == 4'd8) begin
                  data_low_n = ~parity_r;
                  state_n    = ST_PARITY;
                end else begin
                  data_low_n = ~shift_r[bit_cnt_r[2:0]];
                  bit_cnt_n  = bit_cnt_r + 4'd1;
                end
              end else begin
                data_low_n = ps2_data_low;
              end
            end
            ST_PARITY: begin
              if (fall_s) begin
                data_low_n = 1'b0;
                state_n    = ST_STOP;
              end else begin
                data_low_n = ps2_data_low;
              end
            end
            ST_STOP: begin
              data_low_n = 1'b0;
              if (fall_s) begin
                if (data_now_s) begin
                  timer_n = {TW{1'b0}};
                  err_n   = 1'b1;
                  state_n = ST_RECOVER;
                end else begin
                  state_n = ST_ACK;
                end
              end else begin
                state_n = ST_STOP;
              end
            end
            ST_ACK: begin
              data_low_n = 1'b0;
              if (clk_now_s && data_now_s) begin
                timer_n = {TW{1'b0}};
                done_n  = 1'b1;
                state_n = ST_IDLE;
              end else begin
                state_n = ST_ACK;
              end
            end
            default: state_n = ST_IDLE;
          endcase
        end
      end
      ST_RECOVER: begin
        if (clk_en) begin
          if (clk_now_s) begin
            if (timer_r == TW'(1)) begin
              timer_n = {TW{1'b0}};
              state_n = ST_IDLE;
            end else begin
              timer_n = timer_r + TW'(1);
            end
          end else begin
            timer_n = {TW{1'b0}};
          end
        end else begin
          timer_n = timer_r;
        end
      end
      default: begin
        timer_n = {TW{1'b0}};
        state_n = ST_IDLE;
      end
    endcase
  end

  // Registered outputs; reset releases both lines without waiting for a clock
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      tx_ready     <= 1'b1;
      rx_inhibit   <= 1'b0;
      tx_done      <= 1'b0;
      tx_error     <= 1'b0;
    end else begin
      ps2_clk_low  <= clk_low_n;
      ps2_data_low <= data_low_n;
      tx_ready     <= (state_n == ST_IDLE);
      rx_inhibit   <= (state_n != ST_IDLE);
      tx_done      <= done_n;
      tx_error     <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain keyboard model clocks frames out of the
// host, and a scoreboard of expected bytes/parity is compared against what the model captures.
module tb_ps2_host_tx;

  localparam int H = 10;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_low, ps2_data_low;
  logic       rx_inhibit, tx_done, tx_error;
  logic       kb_clk_low = 1'b0;
  logic       kb_data_low = 1'b0;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int inh_strobes = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic done_idle = 1'b0, err_inh = 1'b0;

  typedef struct { logic [7:0] data; logic par; } exp_t;
  exp_t sb_q[$];

  assign ps2_clk_in  = ~(ps2_clk_low | kb_clk_low);
  assign ps2_data_in = ~(ps2_data_low | kb_data_low);

  ps2_host_tx dut (
    .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_low(ps2_clk_low), .ps2_data_low(ps2_data_low), .rx_inhibit(rx_inhibit),
    .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  // Timebase strobe on every other clock
  initial forever begin
    @(posedge clk);
    #1 clk_en = ~clk_en;
  end

  // Event monitors sampled on the inactive edge
  always @(negedge clk) begin
    if (ps2_clk_low && clk_en) inh_strobes <= inh_strobes + 1;
    if (tx_done) begin
      done_cnt  <= done_cnt + 1;
      done_idle <= tx_ready && !rx_inhibit;
    end
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_inh <= rx_inhibit;
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
  end

  function automatic exp_t make_exp(input logic [7:0] b);
    exp_t e;
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    e.data = b;
    e.par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return e;
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    tx_data = ~b;
  endtask

  // Keyboard model: waits for the request-to-send, clocks 11 pulses, samples on high phase
  task automatic kb_frame(input bit do_ack, output logic [7:0] d, output logic par,
                          output logic stop, output logic start, output bit ok);
    int n = 0;
    ok = 1'b0; d = 8'h00; par = 1'b0; stop = 1'b0; start = 1'b1;
    while (!(ps2_clk_in && !ps2_data_in) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) return;
    start = ps2_data_in;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      kb_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      kb_clk_low = 1'b0;
      repeat (H/2) @(negedge clk);
      if (i <= 8) d[i-1] = ps2_data_in;
      else if (i == 9) par = ps2_data_in;
      else if (i == 10) begin
        stop = ps2_data_in;
        if (do_ack) kb_data_low = 1'b1;
      end
      repeat (H/2) @(negedge clk);
    end
    kb_data_low = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if ({tx_ready, rx_inhibit, ps2_clk_low, ps2_data_low, tx_done, tx_error} !== 6'b100000)
      $display("FAIL reset_outputs: got %b want 100000",
               {tx_ready, rx_inhibit, ps2_clk_low, ps2_data_low, tx_done, tx_error});
    else pass_cnt++;
  endtask

  task automatic test_frame(input logic [7:0] b);
    int d0 = done_cnt, e0 = err_cnt, i0 = inh_strobes, n = 0;
    logic [7:0] d; logic par, stop, start; bit ok;
    exp_t e;
    sb_q.push_back(make_exp(b));
    start_tx(b);
    kb_frame(1'b1, d, par, stop, start, ok);
    chk_cnt++;
    if (!ok || sb_q.size() == 0) begin
      $display("FAIL frame_%h_start: got no request-to-send", b);
      return;
    end else pass_cnt++;
    e = sb_q.pop_front();
    chk_cnt++;
    if ({start, d, par, stop} !== {1'b0, e.data, e.par, 1'b1})
      $display("FAIL frame_%h_bits: got s=%b d=%h p=%b t=%b want s=0 d=%h p=%b t=1",
               b, start, d, par, stop, e.data, e.par);
    else pass_cnt++;
    while (done_cnt == d0 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (done_cnt - d0 != 1 || err_cnt != e0)
      $display("FAIL frame_%h_done: got done=%0d err=%0d want done=1 err=0", b, done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
    chk_cnt++;
    if (done_idle !== 1'b1) $display("FAIL frame_%h_idle_at_done: got %b want 1", b, done_idle);
    else pass_cnt++;
    chk_cnt++;
    if (inh_strobes - i0 != 100)
      $display("FAIL frame_%h_inhibit: got %0d strobes want 100", b, inh_strobes - i0);
    else pass_cnt++;
  endtask

  task automatic test_no_ack();
    int d0 = done_cnt, e0 = err_cnt, n = 0;
    logic [7:0] d; logic par, stop, start; bit ok;
    exp_t e;
    sb_q.push_back(make_exp(8'h3C));
    start_tx(8'h3C);
    kb_frame(1'b0, d, par, stop, start, ok);
    e = sb_q.pop_front();
    chk_cnt++;
    if (!ok || d !== e.data || par !== e.par)
      $display("FAIL noack_bits: got ok=%b d=%h p=%b want ok=1 d=%h p=%b", ok, d, par, e.data, e.par);
    else pass_cnt++;
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (err_cnt - e0 != 1 || done_cnt != d0)
      $display("FAIL noack_result: got err=%0d done=%0d want err=1 done=0", err_cnt - e0, done_cnt - d0);
    else pass_cnt++;
    chk_cnt++;
    if (err_inh !== 1'b1 || tx_ready !== 1'b1)
      $display("FAIL noack_recover: got inhibit_at_err=%b ready=%b want 1 1", err_inh, tx_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, n = 0;
    logic [7:0] d; logic par, stop, start; bit ok;
    exp_t e;
    sb_q.push_back(make_exp(8'hA5));
    @(negedge clk);
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    fork
      kb_frame(1'b1, d, par, stop, start, ok);
      begin
        repeat (6) begin
          repeat (40) @(negedge clk);
          tx_data = 8'($urandom);
        end
        tx_data = 8'h5A;
      end
    join
    e = sb_q.pop_front();
    chk_cnt++;
    if (!ok || d !== e.data || par !== e.par)
      $display("FAIL b2b_first: got ok=%b d=%h p=%b want ok=1 d=%h p=%b", ok, d, par, e.data, e.par);
    else pass_cnt++;
    n = 0;
    while (done_cnt == d0 && n < 500) begin @(negedge clk); n++; end
    sb_q.push_back(make_exp(8'h5A));
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (tx_ready !== 1'b0 || rx_inhibit !== 1'b1)
      $display("FAIL b2b_second_accept: got ready=%b inhibit=%b want 0 1", tx_ready, rx_inhibit);
    else pass_cnt++;
    tx_valid = 1'b0;
    kb_frame(1'b1, d, par, stop, start, ok);
    e = sb_q.pop_front();
    chk_cnt++;
    if (!ok || d !== e.data || par !== e.par)
      $display("FAIL b2b_second: got ok=%b d=%h p=%b want ok=1 d=%h p=%b", ok, d, par, e.data, e.par);
    else pass_cnt++;
    n = 0;
    while (done_cnt < d0 + 2 && n < 500) begin @(negedge clk); n++; end
    chk_cnt++;
    if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int d0, e0, n = 0;
    start_tx(8'h00);
    while (!(ps2_clk_in && !ps2_data_in) && n < 2000) begin @(negedge clk); n++; end
    repeat (H) @(negedge clk);
    repeat (5) begin
      kb_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      kb_clk_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    chk_cnt++;
    if (ps2_data_low !== 1'b1) $display("FAIL midframe_bit4_drive: got %b want 1", ps2_data_low);
    else pass_cnt++;
    d0 = done_cnt;
    e0 = err_cnt;
    #2 nRESET = 1'b0;
    #1;
    chk_cnt++;
    if ({ps2_clk_low, ps2_data_low, rx_inhibit, tx_ready} !== 4'b0001)
      $display("FAIL midframe_async_release: got %b want 0001",
               {ps2_clk_low, ps2_data_low, rx_inhibit, tx_ready});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (done_cnt != d0 || err_cnt != e0)
      $display("FAIL midframe_no_pulse: got done=%0d err=%0d want 0 0", done_cnt - d0, err_cnt - e0);
    else pass_cnt++;
    test_frame(8'hF4);
  endtask

  task automatic test_timeout();
    int d0 = done_cnt, n = 0, cnt = 0;
    start_tx(8'hAA);
    while (ps2_clk_low && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_error && n < 40000) begin
      if (clk_en) cnt++;
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (!tx_error || cnt != 15000)
      $display("FAIL timeout_strobes: got err=%b after %0d strobes want err=1 after 15000", tx_error, cnt);
    else pass_cnt++;
    chk_cnt++;
    if (ps2_clk_low !== 1'b0 || ps2_data_low !== 1'b0)
      $display("FAIL timeout_release: got clk_low=%b data_low=%b want 0 0", ps2_clk_low, ps2_data_low);
    else pass_cnt++;
    n = 0;
    while (!tx_ready && n < 100) begin @(negedge clk); n++; end
    chk_cnt++;
    if (tx_ready !== 1'b1 || done_cnt != d0)
      $display("FAIL timeout_idle: got ready=%b done=%0d want 1 0", tx_ready, done_cnt - d0);
    else pass_cnt++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    nRESET = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame(8'hED);
    test_frame(8'h00);
    test_frame(8'hFF);
    test_no_ack();
    test_back_to_back();
    test_reset_midframe();
    test_timeout();
    chk_cnt++;
    if (both_cnt != 0) $display("FAIL done_error_overlap: got %0d want 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
